// File: rtl/stopwatch_pkg.sv
// Shared constants and state type for the stopwatch time-keeping core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam int unsigned MAX_TENS = 5;
    localparam int unsigned MAX_ONES = 9;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter that wraps at MAX_TENS:MAX_ONES and flags the wrap.
module bcd_mod60 #(
    parameter int unsigned MAX_TENS = stopwatch_pkg::MAX_TENS,
    parameter int unsigned MAX_ONES = stopwatch_pkg::MAX_ONES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    localparam logic [3:0] TENS_TOP = 4'(MAX_TENS);
    localparam logic [3:0] ONES_TOP = 4'(MAX_ONES);

    logic at_top;

    // Terminal value decode and carry out.
    always_comb begin
        at_top = (tens == TENS_TOP) && (ones == ONES_TOP);
        carry  = inc && at_top;
    end

    // Digit register: ones roll into tens, the whole pair wraps to 00.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones == ONES_TOP) begin
                ones <= '0;
                if (tens == TENS_TOP) begin
                    tens <= '0;
                end else begin
                    tens <= tens + 4'd1;
                end
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS core: edge detection on divider enables, run/pause/adjust FSM.
module stopwatch_counter #(
    parameter int unsigned MAX_TENS = stopwatch_pkg::MAX_TENS,
    parameter int unsigned MAX_ONES = stopwatch_pkg::MAX_ONES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_Hz_clock,
    input  logic       two_Hz_clock,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       adjusting,
    output logic       paused
);

    import stopwatch_pkg::*;

    state_t state, state_next;
    logic   resume_paused, resume_next;
    logic   one_prev, two_prev;
    logic   one_armed, two_armed;
    logic   tick1, tick2;
    logic   inc_sec, inc_min;
    logic   sec_carry;

    // Input history for edge detection. The armed bits only set once an input
    // has been seen low, so a level still high across reset release never ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            one_prev  <= 1'b0;
            two_prev  <= 1'b0;
            one_armed <= 1'b0;
            two_armed <= 1'b0;
        end else begin
            one_prev <= one_Hz_clock;
            two_prev <= two_Hz_clock;
            if (!one_Hz_clock) one_armed <= 1'b1;
            if (!two_Hz_clock) two_armed <= 1'b1;
        end
    end

    // Single-cycle ticks on rising edges of the divider enables.
    always_comb begin
        tick1 = one_Hz_clock & ~one_prev & one_armed;
        tick2 = two_Hz_clock & ~two_prev & two_armed;
    end

    // Next state and resume target; adj entry overrides every other input.
    always_comb begin
        state_next  = state;
        resume_next = resume_paused;
        if (adj && (state != ST_ADJUST)) begin
            state_next  = ST_ADJUST;
            resume_next = (state == ST_PAUSED);
        end else begin
            case (state)
                ST_RUN: begin
                    if (pause) state_next = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (pause) state_next = ST_RUN;
                end
                ST_ADJUST: begin
                    if (!adj) begin
                        state_next = resume_paused ? ST_PAUSED : ST_RUN;
                    end else if (pause) begin
                        resume_next = ~resume_paused;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    // State and resume target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_RUN;
            resume_paused <= 1'b0;
        end else begin
            state         <= state_next;
            resume_paused <= resume_next;
        end
    end

    // Field increments are decoded from the current state, so a tick in the
    // cycle that enters ADJUST still counts under the old state.
    always_comb begin
        inc_sec = ((state == ST_RUN) && tick1)
                | ((state == ST_ADJUST) && (sel == SEL_SEC) && tick2);
        inc_min = ((state == ST_RUN) && sec_carry)
                | ((state == ST_ADJUST) && (sel == SEL_MIN) && tick2);
    end

    // Status decodes of the registered state.
    always_comb begin
        adjusting = (state == ST_ADJUST);
        paused    = (state == ST_PAUSED);
    end

    bcd_mod60 #(
        .MAX_TENS(MAX_TENS),
        .MAX_ONES(MAX_ONES)
    ) u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc_sec),
        .tens (sec_tens),
        .ones (sec_ones),
        .carry(sec_carry)
    );

    bcd_mod60 #(
        .MAX_TENS(MAX_TENS),
        .MAX_ONES(MAX_ONES)
    ) u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc_min),
        .tens (min_tens),
        .ones (min_ones),
        .carry()
    );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: vector table plus multi-cycle sequences.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst;
    logic       one_Hz_clock;
    logic       two_Hz_clock;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       adjusting, paused;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        one;
        logic        two;
        logic        pse;
        logic        adj;
        logic        sel;
        logic [15:0] t;
        logic        p;
        logic        a;
    } vec_t;

    vec_t vecs [19];

    stopwatch_counter #(
        .MAX_TENS(5),
        .MAX_ONES(9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .one_Hz_clock(one_Hz_clock),
        .two_Hz_clock(two_Hz_clock),
        .pause       (pause),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .adjusting   (adjusting),
        .paused      (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    function automatic logic [17:0] observed();
        return {min_tens, min_ones, sec_tens, sec_ones, paused, adjusting};
    endfunction

    task automatic check(input string name, input logic [15:0] t, input logic p, input logic a);
        logic [17:0] got;
        logic [17:0] exp;
        got = observed();
        exp = {t, p, a};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got time=%h paused=%b adjusting=%b, want time=%h paused=%b adjusting=%b",
                     name, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // Drive inputs just after a falling edge, return after the next falling edge.
    task automatic apply(input logic o, input logic t, input logic p, input logic a, input logic s);
        one_Hz_clock = o;
        two_Hz_clock = t;
        pause        = p;
        adj          = a;
        sel          = s;
        @(negedge clk);
    endtask

    task automatic pulse1(input logic a, input logic s);
        apply(1'b1, 1'b0, 1'b0, a, s);
        apply(1'b0, 1'b0, 1'b0, a, s);
    endtask

    task automatic pulse2(input logic a, input logic s);
        apply(1'b0, 1'b1, 1'b0, a, s);
        apply(1'b0, 1'b0, 1'b0, a, s);
    endtask

    task automatic reset_dut();
        rst          = 1'b0;
        one_Hz_clock = 1'b0;
        two_Hz_clock = 1'b0;
        pause        = 1'b0;
        adj          = 1'b0;
        sel          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //                one   two   pse   adj   sel   time      p     a
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0103, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0103, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0103, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0104, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0104, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0105, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0105, 1'b0, 1'b0};

        reset_dut();
        check("reset_state", 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].one, vecs[i].two, vecs[i].pse, vecs[i].adj, vecs[i].sel);
            check($sformatf("vec%0d", i), vecs[i].t, vecs[i].p, vecs[i].a);
        end

        // 61 seconds from reset
        reset_dut();
        for (int i = 0; i < 61; i++) pulse1(1'b0, 1'b0);
        check("count_61", 16'h0101, 1'b0, 1'b0);

        // preload 59:58 then wrap the whole clock
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 58; i++) pulse2(1'b1, 1'b0);
        check("adj_min_59", 16'h5901, 1'b0, 1'b1);
        for (int i = 0; i < 57; i++) pulse2(1'b1, 1'b1);
        check("preload_5958", 16'h5958, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("preload_run", 16'h5958, 1'b0, 1'b0);
        pulse1(1'b0, 1'b0);
        check("to_5959", 16'h5959, 1'b0, 1'b0);
        pulse1(1'b0, 1'b0);
        check("wrap_0000", 16'h0000, 1'b0, 1'b0);

        // pause holds the count
        for (int i = 0; i < 5; i++) pulse1(1'b0, 1'b0);
        check("at_0005", 16'h0005, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_enter", 16'h0005, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse1(1'b0, 1'b0);
        check("paused_hold", 16'h0005, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse1(1'b0, 1'b0);
        check("resume_0006", 16'h0006, 1'b0, 1'b0);

        // seconds adjust wraps without carrying into minutes; tick1 ignored
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 52; i++) pulse2(1'b1, 1'b1);
        check("adj_sec_58", 16'h0058, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pulse2(1'b1, 1'b1);
            pulse1(1'b1, 1'b1);
        end
        check("adj_sec_wrap", 16'h0001, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("adj_exit_run", 16'h0001, 1'b0, 1'b0);

        // tick1 and pause in the same cycle
        for (int i = 0; i < 8; i++) pulse1(1'b0, 1'b0);
        check("at_0009", 16'h0009, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("tick_and_pause", 16'h0010, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("adj_from_paused", 16'h0010, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("adj_pause_toggle", 16'h0010, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("adj_exit_toggled", 16'h0010, 1'b0, 1'b0);
        pulse1(1'b0, 1'b0);
        check("run_after_toggle", 16'h0011, 1'b0, 1'b0);

        // ADJUST entered from PAUSED returns to PAUSED
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("adj_back_paused", 16'h0011, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("unpause", 16'h0011, 1'b0, 1'b0);

        // asynchronous reset at 12:34 in ADJUST with one_Hz_clock held high
        reset_dut();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) pulse2(1'b1, 1'b0);
        for (int i = 0; i < 34; i++) pulse2(1'b1, 1'b1);
        check("preload_1234", 16'h1234, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("adj_tick1_ign", 16'h1234, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        adj = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("held_high_no_tick", 16'h0000, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("input_low", 16'h0000, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_edge_after", 16'h0001, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
